// File: rtl/bsc_pkg.sv
// Shared types and step constants for the bounce/skip counter.
// BSC_TURN_HOLD_EN adds the dwell states used to pause one enabled cycle at each bound.
package bsc_pkg;

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_DN       = 2'd1
`ifdef BSC_TURN_HOLD_EN
    ,
    ST_DWELL_HI = 2'd2,
    ST_DWELL_LO = 2'd3
`endif
  } state_t;

  localparam int unsigned STEP_SINGLE = 1;
  localparam int unsigned STEP_DOUBLE = 2;

endpackage

// File: rtl/skip_phase.sv
// Per-direction phase counter; dbl marks the step that should be doubled.
module skip_phase #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic dbl
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  // PERIOD of 0 or 1 pins the phase at zero; dbl then depends only on PERIOD.
  localparam logic [PW-1:0] LAST = (PERIOD > 1) ? PW'(PERIOD - 1) : '0;

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (rst || clr)  phase <= '0;
    else if (adv)    phase <= (phase == LAST) ? '0 : phase + 1'b1;
  end

  assign dbl = (PERIOD != 0) && (phase == LAST);

endmodule

// File: rtl/bounce_skip_counter.sv
// Up/down bounce counter between LO and HI with a periodically doubled step per direction.
// Define BSC_TURN_HOLD_EN to dwell one enabled cycle at each bound before reversing.
module bounce_skip_counter
  import bsc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LO        = 1,
  parameter int HI        = 14,
  parameter int UP_PERIOD = 2,
  parameter int DN_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] result,
  output logic             dir,
  output logic             turn
);
  localparam logic [WIDTH-1:0] LO_W = LO[WIDTH-1:0];
  localparam logic [WIDTH-1:0] HI_W = HI[WIDTH-1:0];
  localparam logic [WIDTH:0]   LO_X = LO[WIDTH:0];
  localparam logic [WIDTH:0]   HI_X = HI[WIDTH:0];

  state_t           state, state_nxt;
  dir_t             dir_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             turn_nxt;
  logic             up_dbl, dn_dbl, up_adv, dn_adv, up_clr, dn_clr;
  logic [WIDTH:0]   up_step, dn_step, up_sum, dn_lim;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < LO_W) return LO_W;
    if (v > HI_W) return HI_W;
    return v;
  endfunction

  skip_phase #(.PERIOD(UP_PERIOD)) u_up_phase (
    .clk(clk), .rst(rst), .clr(up_clr), .adv(up_adv), .dbl(up_dbl)
  );

  skip_phase #(.PERIOD(DN_PERIOD)) u_dn_phase (
    .clk(clk), .rst(rst), .clr(dn_clr), .adv(dn_adv), .dbl(dn_dbl)
  );

  assign up_step = up_dbl ? STEP_DOUBLE[WIDTH:0] : STEP_SINGLE[WIDTH:0];
  assign dn_step = dn_dbl ? STEP_DOUBLE[WIDTH:0] : STEP_SINGLE[WIDTH:0];
  assign up_sum  = {1'b0, result} + up_step;
  // Down test compares against LO+step so nothing is ever subtracted below zero.
  assign dn_lim  = LO_X + dn_step;

  always_comb begin
    state_nxt = state;
    res_nxt   = result;
    turn_nxt  = 1'b0;
    up_adv    = 1'b0;
    dn_adv    = 1'b0;
    up_clr    = 1'b0;
    dn_clr    = 1'b0;
    if (load) begin
      state_nxt = ST_UP;
      res_nxt   = clamp(load_val);
      up_clr    = 1'b1;
      dn_clr    = 1'b1;
    end else if (en) begin
      case (state)
        ST_UP: begin
          up_adv = 1'b1;
          if (up_sum >= HI_X) begin
            res_nxt  = HI_W;
            dn_clr   = 1'b1;
            turn_nxt = 1'b1;
`ifdef BSC_TURN_HOLD_EN
            state_nxt = ST_DWELL_HI;
`else
            state_nxt = ST_DN;
`endif
          end else begin
            res_nxt = up_sum[WIDTH-1:0];
          end
        end
        ST_DN: begin
          dn_adv = 1'b1;
          if ({1'b0, result} <= dn_lim) begin
            res_nxt  = LO_W;
            up_clr   = 1'b1;
            turn_nxt = 1'b1;
`ifdef BSC_TURN_HOLD_EN
            state_nxt = ST_DWELL_LO;
`else
            state_nxt = ST_UP;
`endif
          end else begin
            res_nxt = result - dn_step[WIDTH-1:0];
          end
        end
`ifdef BSC_TURN_HOLD_EN
        ST_DWELL_HI: state_nxt = ST_DN;
        ST_DWELL_LO: state_nxt = ST_UP;
`endif
        default: state_nxt = ST_UP;
      endcase
    end
  end

  // Direction already reads "down" while dwelling at HI.
  always_comb begin
    dir_nxt = DIR_UP;
    case (state_nxt)
      ST_DN:       dir_nxt = DIR_DN;
`ifdef BSC_TURN_HOLD_EN
      ST_DWELL_HI: dir_nxt = DIR_DN;
`endif
      default:     dir_nxt = DIR_UP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_UP;
      result <= LO_W;
      dir    <= DIR_UP;
      turn   <= 1'b0;
    end else begin
      state  <= state_nxt;
      result <= res_nxt;
      dir    <= dir_nxt;
      turn   <= turn_nxt;
    end
  end

endmodule

// File: tb/tb_bounce_skip_counter.sv
// Scoreboard bench: stimulus pushes expected outputs from a step-count reference model.
module tb_bounce_skip_counter;
  localparam int W = 4, LO = 1, HI = 14, UPP = 2, DNP = 4;
`ifdef BSC_TURN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] result;
  logic         dir, turn;

  always #5 clk = ~clk;

  bounce_skip_counter #(.WIDTH(W), .LO(LO), .HI(HI), .UP_PERIOD(UPP), .DN_PERIOD(DNP)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .result(result), .dir(dir), .turn(turn)
  );

  typedef struct {int r; bit d; bit t; int tag;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int errors = 0, checks = 0;

  // Reference: counts steps taken since entering the current direction.
  int m_res, m_up_n, m_dn_n;
  bit m_dn, m_dwell, m_turn;

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "sweep";
      2: return "overshoot";
      3: return "load_clamp";
      4: return "load_down";
      5: return "en_hold";
      6: return "rst_prio";
      default: return "random";
    endcase
  endfunction

  task automatic model(input bit r, input bit l, input bit e, input int lv);
    int s;
    m_turn = 1'b0;
    if (r || l) begin
      m_res   = r ? LO : (lv < LO ? LO : (lv > HI ? HI : lv));
      m_dn    = 1'b0;
      m_up_n  = 0;
      m_dn_n  = 0;
      m_dwell = 1'b0;
    end else if (e) begin
      if (m_dwell) begin
        m_dwell = 1'b0;
      end else if (!m_dn) begin
        m_up_n++;
        s = (UPP != 0 && (m_up_n % UPP) == 0) ? 2 : 1;
        if (m_res + s >= HI) begin
          m_res = HI; m_dn = 1'b1; m_dn_n = 0; m_turn = 1'b1; m_dwell = HOLD;
        end else m_res = m_res + s;
      end else begin
        m_dn_n++;
        s = (DNP != 0 && (m_dn_n % DNP) == 0) ? 2 : 1;
        if (m_res - s <= LO) begin
          m_res = LO; m_dn = 1'b0; m_up_n = 0; m_turn = 1'b1; m_dwell = HOLD;
        end else m_res = m_res - s;
      end
    end
  endtask

  // want_r >= 0 substitutes a literal expected result (turn implied at the bounds).
  task automatic drive(input bit r, input bit l, input bit e, input int lv,
                       input int tag, input int want_r);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; en = e; load_val = lv[W-1:0];
    model(r, l, e, lv);
    x.r = (want_r >= 0) ? want_r : m_res;
    x.t = (want_r >= 0) ? (want_r == HI || want_r == LO) : m_turn;
    x.d = m_dn;
    x.tag = tag;
    q.push_back(x);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        checks++;
        if (result !== mon_e.r[W-1:0] || dir !== mon_e.d || turn !== mon_e.t) begin
          errors++;
          $display("FAIL %s: got result=%0d dir=%0b turn=%0b, want result=%0d dir=%0b turn=%0b",
                   tag_name(mon_e.tag), result, dir, turn, mon_e.r, mon_e.d, mon_e.t);
        end
      end
    end
  end

  initial begin : stim
    int seq[22] = '{2, 4, 5, 7, 8, 10, 11, 13, 14, 13, 12, 11, 9, 8, 7, 6, 4, 3, 2, 1, 2, 4};
    int budget;
    drive(1, 0, 0, 0, 0, -1);
    drive(1, 1, 1, 5, 6, -1);
    for (int i = 0; i < 22; i++) drive(0, 0, 1, 0, 1, HOLD ? -1 : seq[i]);
    // 12 -> 13 leaves the up phase on a doubled step; 13+2 clamps to 14.
    drive(0, 1, 0, 12, 2, -1);
    drive(0, 0, 1, 0, 2, -1);
    drive(0, 0, 1, 0, 2, -1);
    drive(0, 1, 0, 0, 3, -1);
    drive(0, 1, 1, 15, 3, -1);
    drive(0, 1, 0, 12, 4, -1);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 4, -1);
    drive(0, 1, 1, 7, 4, -1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 4, -1);
    drive(0, 0, 1, 0, 5, -1);
    drive(0, 0, 0, 3, 5, -1);
    drive(0, 0, 0, 9, 5, -1);
    drive(0, 0, 1, 0, 5, -1);
    drive(0, 0, 1, 0, 5, -1);
    drive(0, 0, 1, 0, 6, -1);
    drive(1, 1, 1, 9, 6, -1);
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 75, int'($urandom_range(0, 15)), 7, -1);
    end
    @(negedge clk);
    en = 1'b0; load = 1'b0; rst = 1'b0;
    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bounce_skip_counter.md
# bounce_skip_counter

Parametrised up/down "bounce" counter generalising the team's skip-while-counting counters. Counts up from a low bound to a high bound, reverses, and counts back down. A configurable every-Nth step is doubled, with independent periods per direction. Adds enable, synchronous load, a direction output and a turn pulse, and is used as a pattern/address generator in the counter test fabric.

## Interface
- WIDTH, 4, counter width in bits (≥3)
- LO, 1, low bound; reversal point when counting down
- HI, 14, high bound; reversal point when counting up; requires LO+2 ≤ HI ≤ 2^WIDTH−1
- UP_PERIOD, 2, every UP_PERIOD-th up step is +2; 0 = never double, 1 = always double
- DN_PERIOD, 4, every DN_PERIOD-th down step is −2; same encoding as UP_PERIOD
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance one step this cycle
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  load value; clamped into [LO,HI]
- result  out  WIDTH  current count, registered
- dir  out  1  0 = counting up, 1 = counting down, registered
- turn  out  1  one-cycle pulse, high in the cycle result first equals a bound after a reversal

## Operation
- Priority: rst > load > en > hold.
- Reset values: result=LO, dir=0, turn=0, up and down phase counters=0.
- load: result=clamp(load_val,LO,HI), dir=0, both phases=0, turn=0. This applies even mid-sweep.
- en=0 and no load: all state holds; turn=0.
- Up step (dir=0): step=2 if UP_PERIOD≠0 and up_phase==UP_PERIOD−1, else step=1. up_phase wraps modulo UP_PERIOD.
- Down step (dir=1): the same rule using dn_phase and DN_PERIOD.
- Arithmetic is done at WIDTH+1 bits, so there is no wrap-around.
- Up: if result+step ≥ HI, then result=HI, dir=1, dn_phase=0, turn=1. Overshoot clamps to HI.
- Down: if result−step ≤ LO, then result=LO, dir=0, up_phase=0, turn=1. Undershoot clamps to LO.
- The phase of the inactive direction is not advanced.
- State machine: UP, DOWN, plus DWELL_HI and DWELL_LO when the macro is enabled (see Configuration).

## Timing
- Latency: result, dir and turn reflect an en/load sampled in cycle n at cycle n+1.
- turn is high for exactly one cycle per reversal and never fires on load or reset.
- rst asserted mid-sweep takes effect at the next edge regardless of en or load.

## Configuration
- BSC_TURN_HOLD_EN defined: on reaching a bound the FSM enters DWELL_HI or DWELL_LO.
  - It stays there for one enabled cycle with result unchanged and turn=0.
  - dir flips on entry to the dwell state.
  - The next enabled cycle takes the first step in the new direction.
- BSC_TURN_HOLD_EN undefined: reversal is immediate. The first enabled cycle after reaching a bound already steps away from it. There are no dwell states.

## Structure
- Package bsc_pkg holds:
  - typedef enum logic {DIR_UP, DIR_DN} dir_t
  - FSM state enum
  - STEP_SINGLE=1 and STEP_DOUBLE=2 localparams
- Sub-module skip_phase is instantiated twice (up and down).
  - Parameter PERIOD; ports clk, rst, clr, adv, dbl.
  - Output dbl is high when PERIOD≠0 and phase==PERIOD−1.
- The top level contains the FSM, clamp and step arithmetic, and output registers.

## Test plan
- Defaults, macro off, en=1 after reset: result sequence 1,2,4,5,7,8,10,11,13,14 (turn at 14), then 13,12,11,9,8,7,6,4,3,2,1 (turn at 1), then repeats.
- Overshoot: load_val=13 with up_phase=UP_PERIOD−1 forced by the sequence 12→13 → next result=14 (clamped, not 15), dir=1, turn=1.
- load_val=0 → result=1; load_val=15 → result=14. Load during a down sweep → dir=0 and phases cleared.
- en toggled 1,0,0,1 → result holds during the en=0 cycles, the phase does not advance, and turn stays 0.
- rst asserted with load=1 and en=1 → result=1, dir=0, turn=0 next cycle.
- Macro on, defaults: …,13,14,14(dwell, turn only on the first 14),13,12,… and …,2,1,1,2,4,…
